// File: rtl/fft_feeder_pkg.sv
// Shared definitions for the FFT frame feeder: FSM state encoding,
// default frame geometry and the ADC offset-binary bias.
package fft_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_STREAM  = 2'd2,
    ST_DONE    = 2'd3
  } feeder_state_t;

  localparam int DEFAULT_FFT_LEN = 256;
  localparam int DEFAULT_DATA_W  = 10;

  // Offset-binary bias for the default ADC width (mid-scale code).
  localparam int ADC_OFFSET = 1 << (DEFAULT_DATA_W - 1);

  // Offset-binary bias for an arbitrary ADC width.
  function automatic int adc_offset(input int data_w);
    return 1 << (data_w - 1);
  endfunction

endpackage

// File: rtl/frame_buf.sv
// Simple dual-port frame buffer: synchronous write port and a registered
// read port with one cycle of latency. No reset on the array or the read
// register so it maps onto block or distributed RAM.
module frame_buf #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port: one sample per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read port: data for raddr appears after the next rising edge.
  always_ff @(posedge clk) begin
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/fft_frame_feeder.sv
// Captures FFT_LEN consecutive ADC samples, converts them from offset
// binary to two's complement, then streams the frame out on AXI-Stream
// with tlast on the final beat.
//
// Handshake: a beat transfers on a rising edge where m_axis_tvalid and
// m_axis_tready are both 1. Once tvalid is raised it stays high, with
// tdata/tlast frozen, until that beat transfers; tvalid never depends
// combinationally on tready.
module fft_frame_feeder
  import fft_feeder_pkg::*;
#(
  parameter int FFT_LEN    = DEFAULT_FFT_LEN,
  parameter int DATA_W     = DEFAULT_DATA_W,
  parameter int OUT_W      = 16,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    ad_data,
  input  logic                 ad_otr,
  output logic [2*OUT_W-1:0]   m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 m_axis_tlast,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 otr_flag,
  output logic [1:0]           dbg_state
);

  localparam int              AW        = $clog2(FFT_LEN);
  localparam int              OFFSET    = adc_offset(DATA_W);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(FFT_LEN - 1);

  feeder_state_t     state_q, state_d;
  logic [AW-1:0]     wr_addr_q, wr_addr_d;
  logic [AW-1:0]     rd_addr_q, rd_addr_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;
  logic              frame_done_q, frame_done_d;
  logic              otr_q, otr_d;

  logic              handshake;
  logic [AW-1:0]     rd_next;
  logic              buf_we;
  logic [OUT_W-1:0]  buf_wdata;
  logic [AW-1:0]     buf_raddr;
  logic [OUT_W-1:0]  buf_rdata;

  // Offset binary to two's complement: subtracting mid-scale in OUT_W bits
  // yields the sign-extended result directly since it always fits.
  always_comb begin
    buf_wdata = OUT_W'(ad_data) - OUT_W'(OFFSET);
  end

  // Read address prefetch: the buffer's output register always holds the
  // beat that is on the bus after the next edge, so re-reading the current
  // address holds the data under backpressure and advancing on a handshake
  // gives back-to-back beats without a bubble.
  always_comb begin
    handshake = tvalid_q & m_axis_tready;
    rd_next   = rd_addr_q + AW'(1);
    buf_raddr = handshake ? rd_next : rd_addr_q;
  end

  // Next-state and next-output logic for the capture/stream FSM.
  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    rd_addr_d = rd_addr_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    otr_d     = otr_q;
    buf_we    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CAPTURE;
          otr_d     = 1'b0;
          wr_addr_d = '0;
        end
      end

      ST_CAPTURE: begin
        buf_we    = 1'b1;
        otr_d     = otr_q | ad_otr;
        wr_addr_d = wr_addr_q + AW'(1);
        if (wr_addr_q == LAST_ADDR) begin
          state_d   = ST_STREAM;
          rd_addr_d = '0;
        end
      end

      ST_STREAM: begin
        if (!tvalid_q) begin
          // First cycle: the read of address 0 was issued this cycle.
          tvalid_d = 1'b1;
          tlast_d  = (rd_addr_q == LAST_ADDR);
        end else if (handshake) begin
          if (tlast_q) begin
            tvalid_d  = 1'b0;
            tlast_d   = 1'b0;
            rd_addr_d = '0;
            state_d   = ST_DONE;
          end else begin
            rd_addr_d = rd_next;
            tlast_d   = (rd_next == LAST_ADDR);
          end
        end
      end

      ST_DONE: begin
        if (CONTINUOUS) begin
          state_d   = ST_CAPTURE;
          otr_d     = 1'b0;
          wr_addr_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // State, counters and registered outputs; reset aborts any frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      otr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      otr_q        <= otr_d;
    end
  end

  frame_buf #(
    .DEPTH (FFT_LEN),
    .WIDTH (OUT_W),
    .AW    (AW)
  ) u_frame_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_addr_q),
    .wdata (buf_wdata),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  // Bus data is forced to zero when no beat is presented, so it reads 0
  // out of reset even though the RAM read register is not reset.
  always_comb begin
    m_axis_tdata = tvalid_q ? {{OUT_W{1'b0}}, buf_rdata} : '0;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign frame_done    = frame_done_q;
  assign otr_flag      = otr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_fft_frame_feeder.sv
// Bench for fft_frame_feeder: directed scenario sequence with randomized
// sample data and tready patterns, checked against a sample-list model.
module tb_fft_frame_feeder;

  localparam int N  = 256;
  localparam int DW = 10;
  localparam int OW = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic            start   = 1'b0;
  logic            start_c = 1'b0;
  logic [DW-1:0]   ad_data = '0;
  logic            ad_otr  = 1'b0;
  logic            tready  = 1'b0;
  logic            tready_c = 1'b0;

  logic [2*OW-1:0] tdata, tdata_c;
  logic            tvalid, tvalid_c, tlast, tlast_c;
  logic            busy, busy_c, frame_done, frame_done_c, otr_flag, otr_flag_c;
  logic [1:0]      dbg_state, dbg_state_c;

  fft_frame_feeder #(
    .FFT_LEN (N), .DATA_W (DW), .OUT_W (OW), .CONTINUOUS (1'b0)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .ad_data (ad_data),
    .ad_otr (ad_otr), .m_axis_tdata (tdata), .m_axis_tvalid (tvalid),
    .m_axis_tready (tready), .m_axis_tlast (tlast), .busy (busy),
    .frame_done (frame_done), .otr_flag (otr_flag), .dbg_state (dbg_state)
  );

  fft_frame_feeder #(
    .FFT_LEN (N), .DATA_W (DW), .OUT_W (OW), .CONTINUOUS (1'b1)
  ) dut_c (
    .clk (clk), .rst_n (rst_n), .start (start_c), .ad_data (ad_data),
    .ad_otr (ad_otr), .m_axis_tdata (tdata_c), .m_axis_tvalid (tvalid_c),
    .m_axis_tready (tready_c), .m_axis_tlast (tlast_c), .busy (busy_c),
    .frame_done (frame_done_c), .otr_flag (otr_flag_c), .dbg_state (dbg_state_c)
  );

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  int          samp [N];
  logic [31:0] exp_q [$];
  logic [31:0] got [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: each beat is {imag 0, sample minus mid-scale}.
  // kind 0: ramp 0..N-1; kind 1: random codes; kind 2: random with the
  // conversion extremes in the first three slots.
  task automatic build_frame(input int kind);
    int v;
    logic [15:0] r;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      case (kind)
        0:       samp[i] = i;
        default: samp[i] = int'($urandom_range(0, (1 << DW) - 1));
      endcase
    end
    if (kind == 2) begin
      samp[0] = 0;
      samp[1] = 512;
      samp[2] = 1023;
    end
    for (int i = 0; i < N; i++) begin
      v = samp[i] - (1 << (DW - 1));
      r = v[15:0];
      exp_q.push_back({16'h0000, r});
    end
  endtask

  // ---------------- driver tasks ----------------
  // Start pulse then N capture cycles; ends #1 after the last write edge.
  task automatic do_capture(input int otr_at, input bit poke_start);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("otr_cleared_on_start", otr_flag, 0);
    chk("state_capture", dbg_state, 1);
    for (int i = 0; i < N; i++) begin
      ad_data = DW'(samp[i]);
      ad_otr  = (i == otr_at);
      start   = (poke_start && i == N / 2);
      @(posedge clk); #1;
    end
    ad_otr = 1'b0;
    start  = 1'b0;
    chk("prefetch_cycle_tvalid", tvalid, 0);
    chk("otr_after_capture", otr_flag, (otr_at >= 0));
  endtask

  // Consume the frame; optional random backpressure and mid-frame reset.
  task automatic do_stream(input bit rand_ready, input int abort_at,
                           input logic exp_otr, input bit check_timing);
    int beat = 0;
    int cyc = 0;
    int first_v = -1;
    int last_acc = -1;
    int low_run = 0;
    logic pv = 1'b0, pr = 1'b0, pl = 1'b0;
    logic [31:0] pd = '0;
    bit acc;
    while (beat < N && cyc < 40 * N) begin
      if (beat == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_tdata", tdata, 0);
        #2;
        rst_n  = 1'b1;
        tready = 1'b0;
        ad_otr = 1'b0;
        return;
      end
      if (!rand_ready) tready = 1'b1;
      else if (low_run > 0) begin tready = 1'b0; low_run--; end
      else if ($urandom_range(0, 15) == 0) begin
        low_run = int'($urandom_range(4, 24));
        tready  = 1'b0;
      end else tready = 1'($urandom_range(0, 1));
      ad_otr = 1'($urandom_range(0, 1));  // ADC is not sampled while streaming
      if (pv) chk("tvalid_held", tvalid, 1);
      if (tvalid) begin
        if (first_v < 0) first_v = cyc;
        chk("tdata", tdata, exp_q[beat]);
        chk("tlast", tlast, (beat == N - 1));
        if (beat < 3) got[beat] = tdata;
        if (pv && !pr) begin
          chk("hold_tdata", tdata, pd);
          chk("hold_tlast", tlast, pl);
        end
      end
      acc = tvalid && tready;
      pv = tvalid; pr = tready; pd = tdata; pl = tlast;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        beat++;
        if (beat == N) last_acc = cyc;
      end
    end
    ad_otr = 1'b0;
    if (beat < N) chk("stream_timeout_beats", beat, N);
    if (check_timing) begin
      chk("first_tvalid_edge", N + first_v, N + 1);
      chk("last_accept_edge", N + last_acc, 2 * N + 1);
    end
    chk("done_pulse", frame_done, 1);
    chk("done_tvalid_low", tvalid, 0);
    chk("done_tlast_low", tlast, 0);
    chk("done_busy", busy, 1);
    chk("done_otr", otr_flag, exp_otr);
    chk("state_done", dbg_state, 3);
    tready = 1'b0;
    @(posedge clk); #1;
    chk("after_done_pulse", frame_done, 0);
    chk("after_done_busy", busy, 0);
    chk("after_done_otr", otr_flag, exp_otr);
    chk("state_idle", dbg_state, 0);
  endtask

  // Continuous-mode instance: frames back to back, start pulses ignored.
  task automatic run_continuous();
    int cyc = 0;
    int pulses = 0;
    int last_pulse = 0;
    int beats = 0;
    tready_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b1;
    @(posedge clk); #1; start_c = 1'b0;
    while (pulses < 3 && cyc < 4000) begin
      ad_data = DW'($urandom_range(0, (1 << DW) - 1));
      start_c = (cyc % 100 == 7);
      if (tvalid_c) beats++;
      if (frame_done_c) begin
        if (pulses == 0) chk("cont_first_done", cyc, 2 * N + 1);
        else             chk("cont_period", cyc - last_pulse, 2 * N + 2);
        chk("cont_beats", beats, N);
        chk("cont_busy_in_done", busy_c, 1);
        beats = 0;
        last_pulse = cyc;
        pulses++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start_c = 1'b0;
    chk("cont_pulse_count", pulses, 3);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1 rst_n = 1'b0;
    #10;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_tdata", tdata, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_done", frame_done, 0);
    chk("reset_otr", otr_flag, 0);
    chk("reset_state", dbg_state, 0);
    chk("reset_c_busy", busy_c, 0);
    chk("reset_c_tvalid", tvalid_c, 0);
    rst_n = 1'b1;

    // Ramp with tready high, including latency checks.
    build_frame(0);
    do_capture(-1, 1'b0);
    do_stream(1'b0, -1, 1'b0, 1'b1);

    // Same ramp under random backpressure; start poked mid-capture.
    build_frame(0);
    do_capture(-1, 1'b1);
    do_stream(1'b1, -1, 1'b0, 1'b0);

    // Over-range pulse mid-capture, then a clean frame clears it.
    build_frame(1);
    do_capture(N / 3, 1'b0);
    do_stream(1'b1, -1, 1'b1, 1'b0);
    build_frame(1);
    do_capture(-1, 1'b0);
    do_stream(1'b0, -1, 1'b0, 1'b0);

    // Conversion extremes, compared against fixed codes as well.
    build_frame(2);
    do_capture(-1, 1'b0);
    do_stream(1'b0, -1, 1'b0, 1'b0);
    chk("conv_code_0", got[0], 32'h0000_FE00);
    chk("conv_code_512", got[1], 32'h0000_0000);
    chk("conv_code_1023", got[2], 32'h0000_01FF);

    // Reset at beat 100, then a fresh full frame from sample 0.
    build_frame(1);
    do_capture(-1, 1'b0);
    do_stream(1'b1, 100, 1'b0, 1'b0);
    chk("post_reset_state", dbg_state, 0);
    build_frame(0);
    do_capture(-1, 1'b0);
    do_stream(1'b0, -1, 1'b0, 1'b1);

    run_continuous();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
